// File: rtl/e_muldiv_unit.sv
// HI/LO multiply/divide unit for the E stage.
// Result is computed at accept and released to HI/LO after a fixed latency.
module e_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] L_MUL = CW'(MUL_LAT);
  localparam logic [CW-1:0] L_DIV = CW'(DIV_LAT);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] D_ONE    = WIDTH'(1);

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_pend;
  logic [CW-1:0]      r_cnt;

  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [2*WIDTH-1:0] w_next;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_start;
  logic               w_idle;
  logic               w_mthi;
  logic               w_mtlo;
  logic [CW-1:0]      w_lat;

  logic               w_div_zero;
  logic               w_div_ovf;
  logic [WIDTH-1:0]   w_dsor_s;
  logic [WIDTH-1:0]   w_dsor_u;
  logic [WIDTH-1:0]   w_q_s;
  logic [WIDTH-1:0]   w_r_s;
  logic [WIDTH-1:0]   w_q_u;
  logic [WIDTH-1:0]   w_r_u;

  assign w_acc    = {r_hi, r_lo};
  assign w_prod_s = {{WIDTH{A[WIDTH-1]}}, A}
                  * {{WIDTH{B[WIDTH-1]}}, B};
  assign w_prod_u = {{WIDTH{1'b0}}, A}
                  * {{WIDTH{1'b0}}, B};

  // Divisor is forced to 1 in the special cases so the
  // divider never sees a zero or overflowing operand pair.
  assign w_div_zero = (B == '0);
  assign w_div_ovf  = (A == MOST_NEG) && (B == ONES);
  assign w_dsor_s   = (w_div_zero || w_div_ovf) ? D_ONE : B;
  assign w_dsor_u   = w_div_zero ? D_ONE : B;

  assign w_q_s = $signed(A) / $signed(w_dsor_s);
  assign w_r_s = $signed(A) % $signed(w_dsor_s);
  assign w_q_u = A / w_dsor_u;
  assign w_r_u = A % w_dsor_u;

  // Decode the op and form the 2W result it would commit.
  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_next   = w_acc;
    case (op)
      OP_MULT: begin
        w_is_mul = 1'b1;
        w_next   = w_prod_s;
      end
      OP_MULTU: begin
        w_is_mul = 1'b1;
        w_next   = w_prod_u;
      end
      OP_MADD: begin
        w_is_mul = 1'b1;
        w_next   = w_acc + w_prod_s;
      end
      OP_MADDU: begin
        w_is_mul = 1'b1;
        w_next   = w_acc + w_prod_u;
      end
      OP_MSUB: begin
        w_is_mul = 1'b1;
        w_next   = w_acc - w_prod_s;
      end
      OP_MSUBU: begin
        w_is_mul = 1'b1;
        w_next   = w_acc - w_prod_u;
      end
      OP_DIV: begin
        w_is_div = 1'b1;
        if (w_div_zero)
          w_next = {A, ONES};
        else if (w_div_ovf)
          w_next = {{WIDTH{1'b0}}, MOST_NEG};
        else
          w_next = {w_r_s, w_q_s};
      end
      OP_DIVU: begin
        w_is_div = 1'b1;
        if (w_div_zero)
          w_next = {A, ONES};
        else
          w_next = {w_r_u, w_q_u};
      end
      default: begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
      end
    endcase
  end

  assign w_start = w_is_mul | w_is_div;
  assign w_idle  = (r_cnt == '0);
  assign w_mthi  = (op == OP_MTHI);
  assign w_mtlo  = (op == OP_MTLO);
  assign w_lat   = w_is_div ? L_DIV : L_MUL;

  assign busy = (w_start & ~flush) | ~w_idle;

  // MF read port, independent of busy.
  always_comb begin
    out = '0;
    if (op == OP_MFHI)
      out = r_hi;
    else if (op == OP_MFLO)
      out = r_lo;
  end

  // Accept, countdown, commit and cancel of HI/LO ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else if (r_cnt == C_ONE) begin
      {r_hi, r_lo} <= r_pend;
      r_cnt        <= '0;
    end else if (!w_idle) begin
      r_cnt <= r_cnt - C_ONE;
    end else if (w_start) begin
      r_pend <= w_next;
      r_cnt  <= w_lat;
    end else if (w_mthi) begin
      r_hi <= A;
    end else if (w_mtlo) begin
      r_lo <= A;
    end
  end

endmodule

// File: doc/e_muldiv_unit.md
Name: e_muldiv_unit

Overview:
- Parametrised HI/LO multiply/divide unit in the E stage of the MIPS pipeline.
- Adds the following over the previous generation:
  - configurable data width and latencies;
  - multiply-accumulate/subtract (madd/maddu/msub/msubu);
  - a flush input that cancels an in-flight operation on exception or branch squash;
  - fully defined divide-by-zero and overflow results.
- Stall logic in the hazard unit consumes busy.

Parameters:
- WIDTH, 32: operand, HI and LO width.
- MUL_LAT, 5: cycles from accepted mult-class op to HI/LO commit; must be >= 1.
- DIV_LAT, 10: cycles from accepted div-class op to HI/LO commit; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  4  operation:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO;
  - 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU;
  - 13-15 behave as NONE.
- A  input  WIDTH  rs operand; dividend for div-class ops; source for mt.
- B  input  WIDTH  rt operand; divisor for div-class ops.
- flush  input  1  cancel in-flight op and ignore this cycle's op.
- out  output  WIDTH  mf result (combinational).
- busy  output  1  unit occupied; hazard unit stalls on it.

Behaviour:
- State:
  - hi, lo, WIDTH each;
  - pending hi/lo, 2*WIDTH;
  - counter cnt, width clog2(max(MUL_LAT,DIV_LAT)+1).
  - Idle when cnt==0.
- Reset: cnt=0, hi=lo=0, pending=0. out=0, and busy=0 when op=NONE. Reset mid-operation discards the op.
- start = op is in {MULT, MULTU, DIV, DIVU, MADD..MSUBU}.
- busy = (start & !flush) | (cnt!=0), combinational.
- Accept: at the rising edge with cnt==0, start==1 and flush==0:
  - pending is computed from A, B and the current hi/lo;
  - cnt is loaded with MUL_LAT (mult/madd/msub class) or DIV_LAT (div class).
- Countdown: when cnt>1, cnt decrements each edge.
- Commit: when cnt==1, at the next edge {hi,lo}<=pending and cnt<=0.
- Timing: an op accepted at edge N commits at edge N+L. MF reads the new value in the cycle after edge N+L, which is also the first cycle with busy low.
- Start ops presented while cnt!=0 are ignored. The pipeline never issues them, because busy stalls the pipeline.
- MTHI/MTLO:
  - write hi or lo from A at the edge, only when cnt==0 and flush==0;
  - ignored while busy;
  - never set busy.
- MFHI/MFLO:
  - out=hi or lo, combinational, regardless of busy; the stall guarantees freshness.
  - out=0 for all other ops.
- Arithmetic:
  - MULT: signed 2W product. MULTU: unsigned 2W product.
  - MADD: {hi,lo} + signed product, mod 2^(2W). MADDU: unsigned product.
  - MSUB/MSUBU: {hi,lo} minus the product, mod 2^(2W).
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (DIV and DIVU): lo = all ones, hi = A.
- Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0.
- Flush:
  - at the edge where flush==1: cnt<=0 and pending is discarded;
  - hi/lo are unchanged, and any op that cycle (including mt) is ignored;
  - flush on the commit edge (cnt==1) wins, so no commit occurs;
  - busy falls in the following cycle.
- Simultaneous events: rst beats flush; flush beats commit and accept. Commit and a new accept never coincide, because accept requires cnt==0.

Test Plan:
- Reset; op=MULT, A=0xFFFFFFFD, B=5 for one cycle, then NONE:
  - busy high for 6 cycles (issue cycle plus 5);
  - then MFLO gives 0xFFFFFFF1 and MFHI gives 0xFFFFFFFF.
- MULTU A=0xFFFFFFFF, B=2 -> after commit hi=0x00000001, lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2:
  - busy high for 11 cycles;
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Accumulate sequence: MTHI 0; MTLO 10; MADD A=3, B=4 -> lo=22, hi=0. Then MSUB A=5, B=5 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Flush and busy-ignore sequence:
  - hi=lo=0x11; DIV A=100, B=3, with flush raised at the edge where cnt==3;
  - busy drops the next cycle, and hi/lo stay 0x11;
  - MTLO issued while busy is ignored.
- Sweep of flush timing: flush at the cnt==1 edge -> no commit. rst asserted mid-MULT -> hi=lo=0, busy=0.
